// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the M-stage memory channel controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam int CH_SEL_W = 3;

  function automatic logic ch_is_bypass(input logic [7:0] mask,
                                        input logic [CH_SEL_W-1:0] idx);
    return mask[idx];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Stall-cycle counter for one handshake access; flags expiry at TIMEOUT-1.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage memory controller: NCH channels, each zero-wait bypass or req/ack with
// timeout; a pending handshake stalls the pipeline through StallM.
//
// state  | meaning
// IDLE   | no access pending; bypass accesses complete here
// ACCESS | handshake request held on the latched channel, pipeline stalled
// DONE   | result presented with DoneM, pipeline advances
import mem_stage_pkg::*;

module mem_stage_ctrl #(
  parameter int             WIDTH       = 48,
  parameter int             NCH         = 4,
  parameter logic [NCH-1:0] BYPASS_MASK = 4'b0001,
  parameter int             TIMEOUT     = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 ReqM,
  input  logic                 WriteM,
  input  logic [CH_SEL_W-1:0]  ChSelM,
  input  logic [WIDTH-1:0]     AddrM,
  input  logic [WIDTH-1:0]     WDataM,
  output logic                 StallM,
  output logic [WIDTH-1:0]     RDataM,
  output logic                 DoneM,
  output logic                 ErrM,
  output logic [NCH-1:0]       ch_req,
  output logic                 ch_we,
  output logic [WIDTH-1:0]     ch_addr,
  output logic [WIDTH-1:0]     ch_wdata,
  input  logic [NCH*WIDTH-1:0] ch_rdata,
  input  logic [NCH-1:0]       ch_ack
);

  mem_state_t       state_q, state_d;
  logic [NCH-1:0]   sel_oh_q, sel_oh_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [NCH-1:0]   req_oh;
  logic [WIDTH-1:0] byp_rdata, acc_rdata;
  logic             ch_valid, ch_bypass, ack_hit;
  logic             ctr_clear, ctr_enable, ctr_expired;

  always_comb begin
    req_oh    = '0;
    byp_rdata = '0;
    acc_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ChSelM == CH_SEL_W'(i)) begin
        req_oh[i] = 1'b1;
        byp_rdata = ch_rdata[i*WIDTH +: WIDTH];
      end
      if (sel_oh_q[i]) begin
        acc_rdata = ch_rdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ch_valid  = |req_oh;
  assign ch_bypass = ch_is_bypass(8'(BYPASS_MASK), ChSelM);
  assign ack_hit   = |(ch_ack & sel_oh_q);

  // The counter tallies stall cycles of the current access, so the accepting
  // IDLE cycle counts as the first and expiry lands after TIMEOUT stalls.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (CLK),
    .rst_i    (Reset),
    .clear_i  (ctr_clear),
    .enable_i (ctr_enable),
    .expired_o(ctr_expired)
  );

  always_comb begin
    state_d    = state_q;
    sel_oh_d   = sel_oh_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    StallM     = 1'b0;
    DoneM      = 1'b0;
    ErrM       = 1'b0;
    RDataM     = '0;
    ch_req     = '0;
    ch_we      = 1'b0;
    ch_addr    = '0;
    ch_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        ctr_clear = 1'b1;
        if (ReqM) begin
          if (!ch_valid) begin
            StallM  = 1'b1;
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (ch_bypass) begin
            ch_req   = req_oh;
            ch_we    = WriteM;
            ch_addr  = AddrM;
            ch_wdata = WDataM;
            RDataM   = WriteM ? '0 : byp_rdata;
            DoneM    = 1'b1;
          end else begin
            StallM     = 1'b1;
            ctr_clear  = 1'b0;
            ctr_enable = 1'b1;
            sel_oh_d   = req_oh;
            we_d       = WriteM;
            addr_d     = AddrM;
            wdata_d    = WDataM;
            err_d      = 1'b0;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        StallM     = 1'b1;
        ctr_enable = 1'b1;
        ch_req     = sel_oh_q;
        ch_we      = we_q;
        ch_addr    = addr_q;
        ch_wdata   = wdata_q;
        if (ack_hit) begin
          rdata_d = we_q ? '0 : acc_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (ctr_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ctr_clear = 1'b1;
        DoneM     = 1'b1;
        ErrM      = err_q;
        RDataM    = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must silence the combinational outputs at once, not at the next edge.
    if (Reset) begin
      StallM   = 1'b0;
      DoneM    = 1'b0;
      ErrM     = 1'b0;
      RDataM   = '0;
      ch_req   = '0;
      ch_we    = 1'b0;
      ch_addr  = '0;
      ch_wdata = '0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      sel_oh_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_oh_q <= sel_oh_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int             WIDTH       = 48;
  localparam int             NCH         = 4;
  localparam logic [NCH-1:0] BYPASS_MASK = 4'b0001;
  localparam int             TIMEOUT     = 16;
  localparam int             BUSW        = NCH * WIDTH;

  logic                 CLK, Reset, ReqM, WriteM;
  logic [2:0]           ChSelM;
  logic [WIDTH-1:0]     AddrM, WDataM;
  logic                 StallM, DoneM, ErrM, ch_we;
  logic [WIDTH-1:0]     RDataM, ch_addr, ch_wdata;
  logic [NCH-1:0]       ch_req, ch_ack;
  logic [BUSW-1:0]      ch_rdata;

  int n_total, n_pass;

  // model: phase 0 = free, 1 = waiting for ack, 2 = reporting result
  int               m_phase, m_ch, m_nstall;
  logic             m_we, m_fin_err;
  logic [WIDTH-1:0] m_addr, m_wdata, m_fin_data;

  logic             e_stall, e_done, e_err, e_we;
  logic [WIDTH-1:0] e_rdata, e_addr, e_wdata;
  logic [NCH-1:0]   e_req;

  mem_stage_ctrl #(
    .WIDTH(WIDTH), .NCH(NCH), .BYPASS_MASK(BYPASS_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .Reset(Reset), .ReqM(ReqM), .WriteM(WriteM), .ChSelM(ChSelM),
    .AddrM(AddrM), .WDataM(WDataM), .StallM(StallM), .RDataM(RDataM),
    .DoneM(DoneM), .ErrM(ErrM), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit bit_of(input logic [31:0] v, input int i);
    return ((v >> i) & 32'd1) != 32'd0;
  endfunction

  function automatic logic [WIDTH-1:0] lane(input int ch);
    return WIDTH'(ch_rdata >> (ch * WIDTH));
  endfunction

  task automatic set_lane(input int ch, input logic [WIDTH-1:0] d);
    logic [BUSW-1:0] m;
    m = BUSW'({WIDTH{1'b1}}) << (ch * WIDTH);
    ch_rdata = (ch_rdata & ~m) | (BUSW'(d) << (ch * WIDTH));
  endtask

  task automatic rand_lanes();
    logic [BUSW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v = (v << WIDTH) | BUSW'(WIDTH'({$urandom, $urandom}));
    ch_rdata = v;
  endtask

  // Expected outputs for this cycle from the access rules, then the model moves on.
  task automatic model_cycle();
    int ch;
    ch = int'(ChSelM);
    e_stall = 0; e_done = 0; e_err = 0; e_we = 0;
    e_rdata = '0; e_addr = '0; e_wdata = '0; e_req = '0;
    if (Reset) begin
      m_phase = 0;
      return;
    end
    case (m_phase)
      0: if (ReqM) begin
        if (ch >= NCH) begin
          e_stall = 1; m_fin_data = '0; m_fin_err = 1; m_phase = 2;
        end else if (bit_of(32'(BYPASS_MASK), ch)) begin
          e_req = NCH'(1 << ch); e_we = WriteM; e_addr = AddrM; e_wdata = WDataM;
          e_rdata = WriteM ? '0 : lane(ch); e_done = 1;
        end else begin
          e_stall = 1; m_ch = ch; m_we = WriteM; m_addr = AddrM; m_wdata = WDataM;
          m_nstall = 1; m_phase = 1;
        end
      end
      1: begin
        e_stall = 1; e_req = NCH'(1 << m_ch); e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
        m_nstall++;
        if (bit_of(32'(ch_ack), m_ch)) begin
          m_fin_data = m_we ? '0 : lane(m_ch); m_fin_err = 0; m_phase = 2;
        end else if (m_nstall == TIMEOUT) begin
          m_fin_data = '0; m_fin_err = 1; m_phase = 2;
        end
      end
      default: begin
        e_done = 1; e_rdata = m_fin_data; e_err = m_fin_err; m_phase = 0;
      end
    endcase
  endtask

  task automatic settle_check();
    #2;
    model_cycle();
    chk("StallM",   64'(StallM),   64'(e_stall));
    chk("DoneM",    64'(DoneM),    64'(e_done));
    chk("ErrM",     64'(ErrM),     64'(e_err));
    chk("RDataM",   64'(RDataM),   64'(e_rdata));
    chk("ch_req",   64'(ch_req),   64'(e_req));
    chk("ch_we",    64'(ch_we),    64'(e_we));
    chk("ch_addr",  64'(ch_addr),  64'(e_addr));
    chk("ch_wdata", 64'(ch_wdata), 64'(e_wdata));
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  int stall_cnt, ack_pct;

  initial begin
    n_total = 0; n_pass = 0; m_phase = 0;
    Reset = 1; ReqM = 0; WriteM = 0; ChSelM = 0; AddrM = '0; WDataM = '0;
    ch_rdata = '0; ch_ack = '0;

    tick(); settle_check();
    chk("rst_stall", 64'(StallM), 64'h0);
    chk("rst_rdata", 64'(RDataM), 64'h0);
    chk("rst_req",   64'(ch_req), 64'h0);
    tick(); Reset = 0; settle_check();

    // bypass read on ch0
    tick(); ReqM = 1; WriteM = 0; ChSelM = 3'd0; AddrM = 48'h10; rand_lanes();
    set_lane(0, 48'h0000_1234_5678);
    settle_check();
    chk("byp_stall", 64'(StallM), 64'h0);
    chk("byp_done",  64'(DoneM),  64'h1);
    chk("byp_rdata", 64'(RDataM), 64'h0000_1234_5678);
    chk("byp_req",   64'(ch_req), 64'h1);

    // handshake read on ch2, ack in ACCESS cycle 3
    stall_cnt = 0;
    for (int c = 0; c <= 4; c++) begin
      tick(); ReqM = 1; WriteM = 0; ChSelM = 3'd2; AddrM = 48'h80; rand_lanes();
      set_lane(2, 48'hABCD);
      ch_ack = (c == 3) ? 4'b0100 : 4'b0000;
      settle_check();
      if (c < 4) stall_cnt += int'(StallM);
      else begin
        chk("hs_done",  64'(DoneM),  64'h1);
        chk("hs_rdata", 64'(RDataM), 64'hABCD);
        chk("hs_err",   64'(ErrM),   64'h0);
      end
    end
    chk("hs_stall_cycles", 64'(stall_cnt), 64'd4);

    // handshake write on ch1, spurious ack on ch3 before the real one
    for (int c = 0; c <= 4; c++) begin
      tick(); ReqM = 1; WriteM = 1; ChSelM = 3'd1; rand_lanes();
      AddrM  = (c == 0) ? 48'h40 : WIDTH'({$urandom, $urandom});
      WDataM = (c == 0) ? 48'h55 : WIDTH'({$urandom, $urandom});
      ch_ack = (c == 1 || c == 2) ? 4'b1000 : (c == 3) ? 4'b0010 : 4'b0000;
      settle_check();
      if (c >= 1 && c <= 3) begin
        chk("wr_req",   64'(ch_req),   64'h2);
        chk("wr_we",    64'(ch_we),    64'h1);
        chk("wr_addr",  64'(ch_addr),  64'h40);
        chk("wr_wdata", 64'(ch_wdata), 64'h55);
      end else if (c == 4) begin
        chk("wr_done",  64'(DoneM),  64'h1);
        chk("wr_rdata", 64'(RDataM), 64'h0);
      end
    end

    // timeout on ch3, then a late ack in IDLE
    stall_cnt = 0;
    for (int c = 0; c <= TIMEOUT; c++) begin
      tick(); ReqM = 1; WriteM = 0; ChSelM = 3'd3; rand_lanes(); ch_ack = 4'b0011;
      settle_check();
      if (c < TIMEOUT) stall_cnt += int'(StallM);
      else begin
        chk("to_done",  64'(DoneM),  64'h1);
        chk("to_err",   64'(ErrM),   64'h1);
        chk("to_rdata", 64'(RDataM), 64'h0);
      end
    end
    chk("to_stall_cycles", 64'(stall_cnt), 64'(TIMEOUT));
    tick(); ReqM = 0; ch_ack = 4'b1000; settle_check();
    chk("late_ack_done", 64'(DoneM), 64'h0);
    chk("late_ack_req",  64'(ch_req), 64'h0);

    // invalid channel
    tick(); ReqM = 1; WriteM = 0; ChSelM = 3'd5; ch_ack = '0; settle_check();
    chk("inv_stall", 64'(StallM), 64'h1);
    chk("inv_req",   64'(ch_req), 64'h0);
    tick(); settle_check();
    chk("inv_err",   64'(ErrM),   64'h1);
    chk("inv_rdata", 64'(RDataM), 64'h0);

    // reset during ACCESS cycle 2
    for (int c = 0; c <= 2; c++) begin
      tick(); ReqM = 1; WriteM = 0; ChSelM = 3'd2; ch_ack = '0; settle_check();
    end
    #1 Reset = 1;
    m_phase = 0;
    #1;
    chk("rst_acc_req",   64'(ch_req), 64'h0);
    chk("rst_acc_stall", 64'(StallM), 64'h0);
    tick(); ReqM = 0; settle_check();
    tick(); Reset = 0; settle_check();
    chk("rst_acc_nodone", 64'(DoneM), 64'h0);

    // randomized traffic
    ack_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (Reset) Reset = 0;
      else if ($urandom_range(0, 299) == 0) Reset = 1;
      if (m_phase == 0) begin
        ReqM   = ($urandom_range(0, 9) < 7);
        WriteM = $urandom_range(0, 1) == 1;
        ChSelM = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        AddrM  = WIDTH'({$urandom, $urandom});
        WDataM = WIDTH'({$urandom, $urandom});
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 10;
          default: ack_pct = 40;
        endcase
      end
      rand_lanes();
      for (int i = 0; i < NCH; i++)
        ch_ack[i] = ($urandom_range(0, 99) < ((i == int'(ChSelM)) ? ack_pct : 20));
      settle_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
